// File: rtl/mips_mem_pkg.sv
// Shared encodings for the memory-stage load/store unit.
// Op codes, FSM states and lane helpers.
package mips_mem_pkg;
  localparam int REGSIZE = 32;
  localparam int ADDR_W  = 7;
  localparam int LANE_W  = 8;
  localparam int HALF_W  = 16;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  function automatic logic is_misaligned(
    input logic [2:0] op,
    input logic [1:0] lo
  );
    logic word_op;
    logic half_op;
    word_op = (op == OP_LW) || (op == OP_SW);
    half_op = (op == OP_LH) || (op == OP_LHU)
           || (op == OP_SH);
    return (word_op && (lo != 2'b00))
        || (half_op && lo[0]);
  endfunction

  function automatic logic is_load(
    input logic [2:0] op
  );
    return op <= OP_LBU;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory pins.
// master: execute stage + memory; slave: the LSU.
interface load_store_unit_if;
  import mips_mem_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_op;
  logic [ADDR_W-1:0]  req_addr;
  logic [REGSIZE-1:0] req_wdata;
  logic               resp_valid;
  logic [REGSIZE-1:0] resp_data;
  logic               resp_misaligned;
  logic               mem_read;
  logic               mem_write;
  logic [4:0]         mem_addr;
  logic [REGSIZE-1:0] mem_wdata;
  logic [REGSIZE-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr,
    input  req_wdata, mem_rdata,
    output req_ready, resp_valid,
    output resp_data, resp_misaligned,
    output mem_read, mem_write,
    output mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr,
    output req_wdata, mem_rdata,
    input  req_ready, resp_valid,
    input  resp_data, resp_misaligned,
    input  mem_read, mem_write,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Sub-word lane extraction with sign/zero extension,
// and lane merge for byte/halfword read-modify-write.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [2:0]         op,
  input  logic [1:0]         lane,
  input  logic [REGSIZE-1:0] rdata,
  input  logic [HALF_W-1:0]  wdata,
  output logic [REGSIZE-1:0] load_data,
  output logic [REGSIZE-1:0] merged
);
  logic [LANE_W-1:0] b;
  logic [HALF_W-1:0] h;

  always_comb begin
    b = rdata[{lane, 3'b000} +: LANE_W];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    merged    = rdata;
    unique case (1'b1)
      (op == OP_LB):  load_data = {{24{b[7]}}, b};
      (op == OP_LBU): load_data = {24'd0, b};
      (op == OP_LH):  load_data = {{16{h[15]}}, h};
      (op == OP_LHU): load_data = {16'd0, h};
      (op == OP_SB):
        merged[{lane, 3'b000} +: LANE_W] = wdata[7:0];
      (op == OP_SH):
        if (lane[1]) merged[31:16] = wdata;
        else         merged[15:0]  = wdata;
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU: one request at a time, RMW for
// sub-word stores, misaligned requests answered in IDLE.
module load_store_unit
  import mips_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  load_store_unit_if.slave bus
);
  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [REGSIZE-1:0] wdata_q, wdata_d;
  logic [REGSIZE-1:0] rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               rmis_q, rmis_d;
  logic [REGSIZE-1:0] load_data;
  logic [REGSIZE-1:0] merged;

  lsu_lane_align u_align (
    .op        (op_q),
    .lane      (addr_q[1:0]),
    .rdata     (bus.mem_rdata),
    .wdata     (wdata_q[HALF_W-1:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  assign bus.resp_valid      = rvalid_q;
  assign bus.resp_data       = rdata_q;
  assign bus.resp_misaligned = rmis_q;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rmis_d        = rmis_q;
    rvalid_d      = 1'b0;
    bus.req_ready = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = rst_n;
        if (bus.req_valid && rst_n) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (is_misaligned(bus.req_op,
                            bus.req_addr[1:0])) begin
            rvalid_d = 1'b1;
            rmis_d   = 1'b1;
            rdata_d  = '0;
          end else if (bus.req_op == OP_SW) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = addr_q[ADDR_W-1:2];
        if (is_load(op_q)) begin
          rvalid_d = 1'b1;
          rmis_d   = 1'b0;
          rdata_d  = load_data;
          state_d  = IDLE;
        end else begin
          wdata_d = merged;
          state_d = WRITE;
        end
      end
      WRITE: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = addr_q[ADDR_W-1:2];
        bus.mem_wdata = wdata_q;
        rvalid_d      = 1'b1;
        rmis_d        = 1'b0;
        rdata_d       = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rmis_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rmis_q   <= rmis_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word-level
// reference memory, response queue, per-cycle compare.
module tb_load_store_unit;
  import mips_mem_pkg::*;

  logic clk;
  logic rst_n;
  load_store_unit_if bus();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        mis;
    logic        store;
    logic        sw;
    logic [4:0]  widx;
    logic [31:0] wword;
  } exp_t;

  exp_t        q[$];
  logic [31:0] tb_mem [32];
  logic [31:0] ref_mem[32];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic        skip_mem = 1'b0;
  logic [31:0] last_data = '0;
  logic        last_mis = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.mem_write) tb_mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = tb_mem[bus.mem_addr];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    checks++;
    if (bus.mem_read && bus.mem_write) begin
      fails++;
      $display("FAIL rd_wr_overlap: both high at cyc %0d", cyc);
    end
    if (!bus.mem_read && !bus.mem_write) begin
      checks++;
      if (bus.mem_addr !== 5'd0 || bus.mem_wdata !== 32'd0) begin
        fails++;
        $display("FAIL idle_mem: addr %h wdata %h expected 0",
                 bus.mem_addr, bus.mem_wdata);
      end
    end else if (!skip_mem) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL mem_access: unexpected at cyc %0d", cyc);
      end else if (q[0].mis || bus.mem_addr !== q[0].widx
                   || (bus.mem_read && q[0].sw)
                   || (bus.mem_write && !q[0].store)
                   || (bus.mem_write
                       && bus.mem_wdata !== q[0].wword)) begin
        fails++;
        $display("FAIL mem_access: rd %b wr %b addr %h wd %h exp addr %h wd %h",
                 bus.mem_read, bus.mem_write, bus.mem_addr,
                 bus.mem_wdata, q[0].widx, q[0].wword);
      end
    end
    if (q.size() > 0) begin
      checks++;
      if (q[0].due < cyc) begin
        fails++;
        $display("FAIL resp_missing: due %0d now %0d", q[0].due, cyc);
        void'(q.pop_front());
      end
    end
    if (bus.resp_valid) begin
      checks++;
      last_data = bus.resp_data;
      last_mis  = bus.resp_misaligned;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: at cyc %0d", cyc);
      end else begin
        if (q[0].due != cyc || bus.resp_data !== q[0].data
            || bus.resp_misaligned !== q[0].mis) begin
          fails++;
          $display("FAIL resp: cyc %0d data %h mis %b exp cyc %0d data %h mis %b",
                   cyc, bus.resp_data, bus.resp_misaligned,
                   q[0].due, q[0].data, q[0].mis);
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic do_req(input logic [2:0]  op,
                        input logic [6:0]  a,
                        input logic [31:0] d);
    int n;
    int sh;
    exp_t e;
    logic [31:0] w;
    logic [7:0]  by;
    logic [15:0] hw;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      fails++;
      $display("FAIL req_ready_timeout: op %0d", op);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    w  = ref_mem[a[6:2]];
    sh = int'(a[1:0]) * 8;
    by = 8'((w >> sh) & 32'hFF);
    hw = a[1] ? w[31:16] : w[15:0];
    e.mis = ((op == OP_LW || op == OP_SW) && a[1:0] != 2'b00)
         || ((op == OP_LH || op == OP_LHU || op == OP_SH) && a[0]);
    e.store = op >= OP_SW;
    e.sw    = op == OP_SW;
    e.widx  = a[6:2];
    e.data  = '0;
    e.wword = '0;
    if (e.mis) e.due = cyc;
    else if (op == OP_SB || op == OP_SH) e.due = cyc + 2;
    else e.due = cyc + 1;
    if (!e.mis) begin
      case (op)
        OP_LW:  e.data = w;
        OP_LH:  e.data = {{16{hw[15]}}, hw};
        OP_LHU: e.data = {16'd0, hw};
        OP_LB:  e.data = {{24{by[7]}}, by};
        OP_LBU: e.data = {24'd0, by};
        OP_SW:  e.wword = d;
        OP_SH:  e.wword = (w & ~(32'hFFFF << (a[1] * 16)))
                        | ({16'd0, d[15:0]} << (a[1] * 16));
        default: e.wword = (w & ~(32'hFF << sh))
                         | ({24'd0, d[7:0]} << sh);
      endcase
      if (e.store) ref_mem[a[6:2]] = e.wword;
    end
    q.push_back(e);
  endtask

  task automatic expect_last(input string nm,
                             input logic [31:0] exp,
                             input logic mis);
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({nm, "_data"}, last_data, exp);
    chk({nm, "_mis"}, {31'd0, last_mis}, {31'd0, mis});
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({nm, "_resp_data"}, bus.resp_data, 32'd0);
    chk({nm, "_resp_mis"}, {31'd0, bus.resp_misaligned}, 32'd0);
    chk({nm, "_mem_rw"}, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk({nm, "_mem_addr"}, {27'd0, bus.mem_addr}, 32'd0);
    chk({nm, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk_quiet("rst");
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    do_req(OP_SW, 7'h08, 32'hDEADBEEF);
    expect_last("sw", 32'h0, 1'b0);
    chk("sw_mem2", tb_mem[2], 32'hDEADBEEF);
    do_req(OP_LW, 7'h08, 32'h0);
    expect_last("lw", 32'hDEADBEEF, 1'b0);
    do_req(OP_LB, 7'h0B, 32'h0);
    expect_last("lb", 32'hFFFFFFDE, 1'b0);
    do_req(OP_LBU, 7'h0B, 32'h0);
    expect_last("lbu", 32'h000000DE, 1'b0);
    do_req(OP_LH, 7'h08, 32'h0);
    expect_last("lh", 32'hFFFFBEEF, 1'b0);
    do_req(OP_LHU, 7'h08, 32'h0);
    expect_last("lhu", 32'h0000BEEF, 1'b0);
    do_req(OP_SB, 7'h09, 32'h000000AA);
    expect_last("sb", 32'h0, 1'b0);
    chk("sb_mem2", tb_mem[2], 32'hDEADAAEF);
    do_req(OP_LW, 7'h08, 32'h0);
    expect_last("lw_sb", 32'hDEADAAEF, 1'b0);
    do_req(OP_SH, 7'h0A, 32'h00001234);
    expect_last("sh", 32'h0, 1'b0);
    chk("sh_mem2", tb_mem[2], 32'h1234AAEF);
    do_req(OP_LH, 7'h0A, 32'h0);
    expect_last("lh_sh", 32'h00001234, 1'b0);

    do_req(OP_LW, 7'h0D, 32'h0);
    do_req(OP_SH, 7'h0B, 32'hFFFF);
    expect_last("mis", 32'h0, 1'b1);

    do_req(OP_SW, 7'h7C, 32'h0BADF00D);
    do_req(OP_LB, 7'h7F, 32'h0);
    expect_last("w31_lb", 32'h0000000B, 1'b0);
    chk("w31_mem", tb_mem[31], 32'h0BADF00D);
    do_req(OP_LHU, 7'h7E, 32'h0);
    expect_last("w31_lhu", 32'h00000BAD, 1'b0);

    @(negedge clk);
    skip_mem = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SB;
    bus.req_addr  = 7'h09;
    bus.req_wdata = 32'h00000055;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_in_write", {31'd0, bus.mem_write}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    skip_mem = 1'b0;
    #1;
    chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    chk_quiet("abort");
    chk("abort_mem2", tb_mem[2], 32'h1234AAEF);
    repeat (3) @(negedge clk);
    do_req(OP_LW, 7'h08, 32'h0);
    expect_last("lw_after_abort", 32'h1234AAEF, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the execute stage and the 32-word data memory. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's read/write/address/data pins. It performs read-modify-write for byte and halfword stores, and extracts and extends sub-word loads. Misaligned accesses are detected and answered without touching memory.

## Interface
- REGSIZE, 32, data word width (only 32 is supported).
- ADDR_W, 7, byte-address width; word index = addr[ADDR_W-1:2] (5 bits, 32 words).

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_op  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  REGSIZE  store data; low byte/halfword used for SB/SH.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  REGSIZE  extended load result; 0 for stores and faults.
- resp_misaligned  out  1  qualifies resp_valid; access was rejected.
- mem_read  out  1  to memory read.
- mem_write  out  1  to memory write; the memory commits on the next clk edge.
- mem_addr  out  5  word index.
- mem_wdata  out  REGSIZE  word to write.
- mem_rdata  in  REGSIZE  combinational read data from memory.

## Operation
- Lanes are little-endian: byte k = bits 8k+7:8k, selected by addr[1:0]; halfword = addr[1] ? 31:16 : 15:0.
- Alignment rules:
  - Misaligned if (LW|SW) and addr[1:0]≠0, or (LH|LHU|SH) and addr[0]≠0.
  - Byte ops are never misaligned.
- FSM states: IDLE, READ, WRITE.
- IDLE:
  - req_ready=1.
  - On handshake, the request is latched.
  - Aligned load or SB/SH → READ.
  - SW → WRITE.
  - Misaligned → stay IDLE and set a resp_valid pulse with resp_misaligned=1 and resp_data=0.
- READ:
  - mem_read=1, mem_addr=latched word index.
  - Load: at the edge, register the extended lane of mem_rdata into resp_data (LB/LH sign-extend; LBU/LHU zero-extend; LW passthrough), pulse resp_valid, → IDLE.
  - SB/SH: at the edge, register the merged word (new lane replaces the selected lane; other lanes are copied from mem_rdata unmodified, X included), → WRITE.
- WRITE:
  - mem_write=1, mem_wdata=req_wdata (SW) or the merged word.
  - At the edge, pulse resp_valid with resp_data=0, → IDLE.
- Outside READ/WRITE: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- mem_read and mem_write are never high in the same cycle.

## Timing
- Reset:
  - state IDLE; resp_valid=0, resp_data=0, resp_misaligned=0.
  - All mem_* outputs 0; req_ready forced 0 while rst_n is low.
- Latency from handshake edge to resp_valid high:
  - misaligned: 1 cycle.
  - load / SW: 2 cycles.
  - SB/SH: 3 cycles.
- resp_valid lasts exactly one cycle. resp_data and resp_misaligned hold until the next response.
- req_ready is high in the same cycle as resp_valid, so back-to-back requests are allowed. Back-to-back misaligned requests produce one pulse per cycle.
- The response is not back-pressured; the consumer must take it on the pulse.
- Reset asserted mid-operation:
  - State clears immediately, so mem_write drops asynchronously and no partial write commits.
  - The pending response is discarded.
- Address 0x7C–0x7F maps to word 31. There is no wrap beyond ADDR_W bits.

## Structure
- Shared package mips_mem_pkg:
  - op encoding constants (OP_LW…OP_SB);
  - FSM state enum;
  - helper constants for lane width (8) and halfword width (16).
- One combinational sub-module, lsu_lane_align (lane extract + sign/zero extend, lane merge), instantiated once. The FSM and registers stay in load_store_unit.

## Test plan
- SW 0xDEADBEEF @0x08: mem_write=1, mem_addr=2 one cycle after the handshake; resp 2 cycles after. Then LW @0x08 → resp_data 0xDEADBEEF at +2 cycles.
- LB @0x0B → 0xFFFFFFDE. LBU @0x0B → 0x000000DE. LH @0x08 → 0xFFFFBEEF. LHU @0x08 → 0x0000BEEF.
- SB 0x000000AA @0x09 → READ cycle, then WRITE with mem_wdata 0xDEADAAEF, resp at +3. LW @0x08 → 0xDEADAAEF.
- SH 0x00001234 @0x0A → writes 0x1234AAEF. LH @0x0A → 0x00001234.
- LW @0x0D and SH @0x0B, back-to-back → two consecutive resp pulses with resp_misaligned=1 and resp_data=0; mem_read/mem_write never asserted.
- Assert rst_n=0 during the WRITE cycle of SB @0x09 → mem_write falls immediately, word 2 is unchanged, no resp_valid. After release, req_ready=1 and all outputs are 0.
